// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - pad reset synchronizer with staged mgmt/user reset release and soft reset replay
// Async-assert/sync-deassert synchronizer feeds a counter FSM that releases mgmt, then user, resets.
module reset_sequencer #(
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 8,
   parameter int SOFT_CYCLES    = 4,
   parameter int CNT_W          = 8
) (
   input  logic core_clk,
   input  logic resetb,
   input  logic sw_reset_req,
   input  logic user_en,
   output logic sync_resetb,
   output logic mgmt_resetb,
   output logic user_resetb,
   output logic seq_done,
   output logic reset_cause
);

   typedef enum logic [1:0] {ST_HOLD, ST_MGMT, ST_RUN, ST_SOFT} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_CYCLES - 1);

   logic sync1_q, sync2_q;

   always_ff @(posedge core_clk or negedge resetb) begin
      if (!resetb) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= 1'b1;
         sync2_q <= sync1_q;
      end
   end

   assign sync_resetb = sync2_q;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mgmt_q, mgmt_d;
   logic             user_q, user_d;
   logic             done_q, done_d;
   logic             cause_q, cause_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mgmt_d  = mgmt_q;
      user_d  = user_q;
      done_d  = done_q;
      cause_d = cause_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = ST_MGMT;
               mgmt_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_MGMT: begin
            if (cnt_q == STAGGER_LAST) begin
               cnt_d   = '0;
               state_d = ST_RUN;
               user_d  = user_en;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            user_d = user_en;
         end
         ST_SOFT: begin
            if (cnt_q == SOFT_LAST) begin
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_HOLD;
         end
      endcase
      // A soft request outranks stagger completion and user_en tracking.
      if (sw_reset_req && (state_q == ST_MGMT || state_q == ST_RUN)) begin
         state_d = ST_SOFT;
         cnt_d   = '0;
         mgmt_d  = 1'b0;
         user_d  = 1'b0;
         done_d  = 1'b0;
         cause_d = 1'b1;
      end
   end

   always_ff @(posedge core_clk or negedge sync_resetb) begin
      if (!sync_resetb) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         mgmt_q  <= 1'b0;
         user_q  <= 1'b0;
         done_q  <= 1'b0;
         cause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mgmt_q  <= mgmt_d;
         user_q  <= user_d;
         done_q  <= done_d;
         cause_q <= cause_d;
      end
   end

   assign mgmt_resetb = mgmt_q;
   assign user_resetb = user_q;
   assign seq_done    = done_q;
   assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (default and all-ones parameters)
// Vectors are {sync_resetb, mgmt_resetb, user_resetb, seq_done, reset_cause}.
module tb_reset_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic resetb0 = 1'b0, sw0 = 1'b0, uen0 = 1'b1;
   logic sync0, mgmt0, user0, done0, cause0;
   logic resetb1 = 1'b0, sw1 = 1'b0, uen1 = 1'b1;
   logic sync1, mgmt1, user1, done1, cause1;

   reset_sequencer dut0 (
      .core_clk(clk), .resetb(resetb0), .sw_reset_req(sw0), .user_en(uen0),
      .sync_resetb(sync0), .mgmt_resetb(mgmt0), .user_resetb(user0),
      .seq_done(done0), .reset_cause(cause0)
   );

   reset_sequencer #(.HOLD_CYCLES(1), .STAGGER_CYCLES(1), .SOFT_CYCLES(1), .CNT_W(8)) dut1 (
      .core_clk(clk), .resetb(resetb1), .sw_reset_req(sw1), .user_en(uen1),
      .sync_resetb(sync1), .mgmt_resetb(mgmt1), .user_resetb(user1),
      .seq_done(done1), .reset_cause(cause1)
   );

   typedef struct {
      int         c;
      logic [4:0] v;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];
   int tests = 0;
   int fails = 0;

   wire [4:0] vec0 = {sync0, mgmt0, user0, done0, cause0};
   wire [4:0] vec1 = {sync1, mgmt1, user1, done1, cause1};

   task automatic at(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
      #1;
   endtask

   task automatic chk_ev(input string n, input int gc, input logic [4:0] gv,
                         input int ec, input logic [4:0] ev);
      tests++;
      if (gc != ec || gv !== ev) begin
         fails++;
         $display("FAIL %s: got cyc=%0d vec=%b, expected cyc=%0d vec=%b", n, gc, gv, ec, ev);
      end
   endtask

   task automatic chk_vec(input string n, input logic [4:0] got, input logic [4:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b", n, got, exp);
      end
   endtask

   task automatic push0(input int c, input logic [4:0] v);
      ev_t e;
      e.c = c;
      e.v = v;
      q0.push_back(e);
   endtask

   task automatic push1(input int c, input logic [4:0] v);
      ev_t e;
      e.c = c;
      e.v = v;
      q1.push_back(e);
   endtask

   logic [4:0] prev0 = 5'b0;
   logic [4:0] prev1 = 5'b0;

   always @(negedge clk) begin
      ev_t e;
      if (vec0 !== prev0) begin
         if (q0.size() == 0) begin
            chk_ev("dut0_unexpected", cyc, vec0, -1, prev0);
         end else begin
            e = q0.pop_front();
            chk_ev("dut0_event", cyc, vec0, e.c, e.v);
         end
         prev0 = vec0;
      end
      if (vec1 !== prev1) begin
         if (q1.size() == 0) begin
            chk_ev("dut1_unexpected", cyc, vec1, -1, prev1);
         end else begin
            e = q1.pop_front();
            chk_ev("dut1_event", cyc, vec1, e.c, e.v);
         end
         prev1 = vec1;
      end
   end

   initial begin
      fork
         begin
            at(3);
            chk_vec("dut0_reset_state", vec0, 5'b00000);
            // power-on release, user_en=1
            push0(7, 5'b10000); push0(23, 5'b11000); push0(31, 5'b11110);
            at(5);  resetb0 = 1'b1;
            // soft pulse in RUN at edge 40
            push0(40, 5'b10001); push0(60, 5'b11001); push0(68, 5'b11111);
            at(39); sw0 = 1'b1;
            at(40); sw0 = 1'b0;
            // soft at 80, ignored pulses in SOFT (82) and HOLD (90)
            push0(80, 5'b10001); push0(100, 5'b11001); push0(108, 5'b11111);
            at(79); sw0 = 1'b1;
            at(80); sw0 = 1'b0;
            at(81); sw0 = 1'b1;
            at(82); sw0 = 1'b0;
            at(89); sw0 = 1'b1;
            at(90); sw0 = 1'b0;
            // soft at 120, then pulse exactly on stagger completion at 148
            push0(120, 5'b10001); push0(140, 5'b11001); push0(148, 5'b10001);
            push0(168, 5'b11001);
            at(119); sw0 = 1'b1;
            at(120); sw0 = 1'b0;
            at(147); sw0 = 1'b1;
            at(148); sw0 = 1'b0;
            // pad reset mid-MGMT, between edges
            push0(170, 5'b00000);
            push0(177, 5'b10000); push0(193, 5'b11000); push0(201, 5'b11110);
            at(170); resetb0 = 1'b0;
            #1;
            chk_vec("dut0_async_clear", vec0, 5'b00000);
            at(175); resetb0 = 1'b1;
            // pad reset, release with user_en=0, then toggle user_en
            push0(210, 5'b00000);
            push0(217, 5'b10000); push0(233, 5'b11000); push0(241, 5'b11010);
            push0(251, 5'b11110); push0(261, 5'b11010);
            at(210); resetb0 = 1'b0; uen0 = 1'b0;
            at(215); resetb0 = 1'b1;
            at(250); uen0 = 1'b1;
            at(260); uen0 = 1'b0;
            // soft request coincident with user_en rising: soft wins
            push0(271, 5'b10001); push0(291, 5'b11001); push0(299, 5'b11111);
            at(270); sw0 = 1'b1; uen0 = 1'b1;
            at(271); sw0 = 1'b0;
         end
         begin
            at(3);
            chk_vec("dut1_reset_state", vec1, 5'b00000);
            push1(7, 5'b10000); push1(8, 5'b11000); push1(9, 5'b11110);
            at(5);  resetb1 = 1'b1;
            push1(20, 5'b10001); push1(22, 5'b11001); push1(23, 5'b11111);
            at(19); sw1 = 1'b1;
            at(20); sw1 = 1'b0;
         end
      join
      at(320);
      tests++;
      if (q0.size() != 0) begin
         fails++;
         $display("FAIL dut0_pending: %0d events never seen, expected 0", q0.size());
      end
      tests++;
      if (q1.size() != 0) begin
         fails++;
         $display("FAIL dut1_pending: %0d events never seen, expected 0", q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
